// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution back-end and its controller.
//   alu_op_e       : opcode encoding, 4'h0..4'hE operations, 4'hF = no operation
//   Sel*           : operation-class codes carried on the Select bus
//   exec_state_e   : execution FSM states
//   expected_sel() : operation class that a given opcode must arrive with
package alu_pkg;

  typedef enum logic [3:0] {
    OpTransfer = 4'h0,
    OpInc      = 4'h1,
    OpAdd      = 4'h2,
    OpSub      = 4'h3,
    OpDec      = 4'h4,
    OpNot      = 4'h5,
    OpAnd      = 4'h6,
    OpNand     = 4'h7,
    OpOr       = 4'h8,
    OpNor      = 4'h9,
    OpXor      = 4'hA,
    OpXnor     = 4'hB,
    OpGt       = 4'hC,
    OpLt       = 4'hD,
    OpEq       = 4'hE,
    OpNop      = 4'hF
  } alu_op_e;

  localparam logic [2:0] SelTransfer = 3'b000;
  localparam logic [2:0] SelArith    = 3'b001;
  localparam logic [2:0] SelLogic    = 3'b010;
  localparam logic [2:0] SelCompare  = 3'b011;
  localparam logic [2:0] SelIdle     = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } exec_state_e;

  // Class grouping follows the controller's Select encoding, which puts AND
  // with the arithmetic group and starts the logic group at NAND.
  function automatic logic [2:0] expected_sel(alu_op_e op);
    logic [2:0] sel;
    if (op == OpTransfer) begin
      sel = SelTransfer;
    end else if (op <= OpAnd) begin
      sel = SelArith;
    end else if (op <= OpXnor) begin
      sel = SelLogic;
    end else if (op <= OpEq) begin
      sel = SelCompare;
    end else begin
      sel = SelIdle;
    end
    return sel;
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU datapath: opcode + operands -> result and status flags.
//   op_i     : operation to perform (OpNop yields zero)
//   a_i, b_i : 8-bit operands
//   result_o : 8-bit result
//   c_o      : carry (add/inc) or borrow (sub/dec), 0 otherwise
//   v_o      : two's-complement overflow for inc/add/sub/dec, 0 otherwise
//   z_o, n_o : result zero / result bit 7, valid for every opcode
module alu_exec_core
  import alu_pkg::*;
(
  input  alu_op_e    op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] result_o,
  output logic       c_o,
  output logic       v_o,
  output logic       z_o,
  output logic       n_o
);

  logic [8:0] sum;
  logic [8:0] diff;
  logic [8:0] dec;

  // Bit 8 of the 9-bit difference is the borrow, i.e. a < subtrahend.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign dec  = {1'b0, a_i} - 9'd1;

  always_comb begin
    result_o = 8'h00;
    c_o      = 1'b0;
    v_o      = 1'b0;
    case (op_i)
      OpTransfer: result_o = a_i;
      OpInc, OpAdd: begin
        result_o = sum[7:0];
        c_o      = sum[8];
        v_o      = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
      end
      OpSub: begin
        result_o = diff[7:0];
        c_o      = diff[8];
        v_o      = (a_i[7] != b_i[7]) && (diff[7] != a_i[7]);
      end
      OpDec: begin
        result_o = dec[7:0];
        c_o      = dec[8];
        // Only 8'h80 - 1 overflows.
        v_o      = a_i[7] && !dec[7];
      end
      OpNot:  result_o = ~a_i;
      OpAnd:  result_o = a_i & b_i;
      OpNand: result_o = ~(a_i & b_i);
      OpOr:   result_o = a_i | b_i;
      OpNor:  result_o = ~(a_i | b_i);
      OpXor:  result_o = a_i ^ b_i;
      OpXnor: result_o = ~(a_i ^ b_i);
      OpGt:   result_o = {7'd0, a_i > b_i};
      OpLt:   result_o = {7'd0, a_i < b_i};
      OpEq:   result_o = {7'd0, a_i == b_i};
      default: result_o = 8'h00;
    endcase
    z_o = (result_o == 8'h00);
    n_o = result_o[7];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution back-end: accepts one opcode/operand transaction, executes it
// and returns a registered result with flags over a valid/ready handshake.
//   Clk, Reset          : clock (rising edge), async active-low reset
//   Controller_Output   : opcode, 4'hF = no operation
//   dataA, dataB        : operands
//   Select              : operation class from the controller
//   Result_Ready        : downstream accepts the result
//   Result, Flag_C/V/Z/N: registered result and status flags
//   Result_Valid        : result and flags valid (DONE state)
//   Sel_Err             : latched Select disagreed with the opcode's class
//   Busy                : a transaction is in flight
//   Op_Count            : completed handshakes, wraps
// Optional feature macro: ALU_SELECT_CHECK_EN enables the Select class check;
// when undefined, Select is ignored and Sel_Err stays 0.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned OPCNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [3:0]         Controller_Output,
  input  logic [7:0]         dataA,
  input  logic [7:0]         dataB,
  input  logic [2:0]         Select,
  input  logic               Result_Ready,
  output logic [7:0]         Result,
  output logic               Result_Valid,
  output logic               Flag_C,
  output logic               Flag_V,
  output logic               Flag_Z,
  output logic               Flag_N,
  output logic               Sel_Err,
  output logic               Busy,
  output logic [OPCNT_W-1:0] Op_Count
);

  exec_state_e        state_q;
  alu_op_e            op_q;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [7:0]         result_q;
  logic               c_q, v_q, z_q, n_q;
  logic               valid_q;
  logic               sel_err_q;
  logic               busy_q;
  logic [OPCNT_W-1:0] op_count_q;

  alu_op_e    new_op;
  logic       handshake;
  logic       accept;
  logic [7:0] core_result;
  logic       core_c, core_v, core_z, core_n;
  logic       sel_mismatch;

  assign new_op    = alu_op_e'(Controller_Output);
  assign handshake = (state_q == StDone) && Result_Ready;
  // New work is taken only when idle or in the same edge as a handshake.
  assign accept    = (new_op != OpNop) && ((state_q == StIdle) || handshake);

`ifdef ALU_SELECT_CHECK_EN
  logic [2:0] sel_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel_q <= SelIdle;
    end else if (accept) begin
      sel_q <= Select;
    end
  end

  assign sel_mismatch = (sel_q != expected_sel(op_q));
`else
  logic unused_select;
  assign unused_select = ^Select;
  assign sel_mismatch  = 1'b0;
`endif

  alu_exec_core u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (core_result),
    .c_o      (core_c),
    .v_o      (core_v),
    .z_o      (core_z),
    .n_o      (core_n)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      result_q   <= 8'h00;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      valid_q    <= 1'b0;
      sel_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        op_q <= new_op;
        a_q  <= dataA;
        b_q  <= dataB;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StExec;
            busy_q  <= 1'b1;
          end
        end
        StExec: begin
          result_q  <= core_result;
          c_q       <= core_c;
          v_q       <= core_v;
          z_q       <= core_z;
          n_q       <= core_n;
          sel_err_q <= sel_mismatch;
          valid_q   <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (handshake) begin
            op_count_q <= op_count_q + {{(OPCNT_W-1){1'b0}}, 1'b1};
            valid_q    <= 1'b0;
            if (accept) begin
              state_q <= StExec;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Result       = result_q;
  assign Result_Valid = valid_q;
  assign Flag_C       = c_q;
  assign Flag_V       = v_q;
  assign Flag_Z       = z_q;
  assign Flag_N       = n_q;
  assign Sel_Err      = sel_err_q;
  assign Busy         = busy_q;
  assign Op_Count     = op_count_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit. A narrow Op_Count keeps the
// wrap scenario short. Inputs change and outputs are sampled on falling edges.
module tb_alu_exec_unit;

  localparam int unsigned CntW = 4;
`ifdef ALU_SELECT_CHECK_EN
  localparam bit SelCheck = 1'b1;
`else
  localparam bit SelCheck = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset;
  logic [3:0]      Controller_Output;
  logic [7:0]      dataA, dataB;
  logic [2:0]      Select;
  logic            Result_Ready;
  logic [7:0]      Result;
  logic            Result_Valid, Flag_C, Flag_V, Flag_Z, Flag_N, Sel_Err, Busy;
  logic [CntW-1:0] Op_Count;

  int              tests = 0;
  int              fails = 0;
  logic [CntW-1:0] exp_cnt = '0;

  alu_exec_unit #(.OPCNT_W(CntW)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Controller_Output (Controller_Output),
    .dataA             (dataA),
    .dataB             (dataB),
    .Select            (Select),
    .Result_Ready      (Result_Ready),
    .Result            (Result),
    .Result_Valid      (Result_Valid),
    .Flag_C            (Flag_C),
    .Flag_V            (Flag_V),
    .Flag_Z            (Flag_Z),
    .Flag_N            (Flag_N),
    .Sel_Err           (Sel_Err),
    .Busy              (Busy),
    .Op_Count          (Op_Count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Starts at a falling edge with the DUT idle; returns at the falling edge
  // after the result is registered, with Ready low so the result is held.
  task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel);
    Result_Ready      = 1'b0;
    Controller_Output = op;
    dataA             = a;
    dataB             = b;
    Select            = sel;
    @(negedge Clk);
    Controller_Output = 4'hF;
    @(negedge Clk);
  endtask

  task automatic handshake();
    Result_Ready = 1'b1;
    @(negedge Clk);
    Result_Ready = 1'b0;
    exp_cnt      = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    logic [18:0] all;
    Reset = 1'b0; Controller_Output = 4'hF; dataA = 8'h00; dataB = 8'h00;
    Select = 3'b100; Result_Ready = 1'b0;
    repeat (2) @(negedge Clk);
    all = {Result, Result_Valid, Flag_C, Flag_V, Flag_Z, Flag_N, Sel_Err, Busy, Op_Count};
    tests++;
    if (all !== 19'h0) begin
      fails++; $display("FAIL reset_state: got %h required %h", all, 19'h0);
    end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    tests++;
    if ({Result_Valid, Busy} !== 2'b00) begin
      fails++; $display("FAIL idle_nop: got %b required 00", {Result_Valid, Busy});
    end
    // Reset in the middle of an add.
    Controller_Output = 4'h2; dataA = 8'hF0; dataB = 8'h20; Select = 3'b001;
    @(negedge Clk);
    tests++;
    if (Busy !== 1'b1) begin
      fails++; $display("FAIL exec_busy: got %b required 1", Busy);
    end
    Controller_Output = 4'hF;
    Reset = 1'b0;
    #1;
    all = {Result, Result_Valid, Flag_C, Flag_V, Flag_Z, Flag_N, Sel_Err, Busy, Op_Count};
    tests++;
    if (all !== 19'h0) begin
      fails++; $display("FAIL reset_mid_exec: got %h required %h", all, 19'h0);
    end
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    tests++;
    if ({Result_Valid, Busy} !== 2'b00) begin
      fails++; $display("FAIL post_reset_idle: got %b required 00", {Result_Valid, Busy});
    end
    exp_cnt = '0;
  endtask

  task automatic test_arith();
    logic [3:0]  ops [4] = '{4'h2, 4'h3, 4'h4, 4'h1};
    logic [7:0]  as  [4] = '{8'hF0, 8'h80, 8'h00, 8'h7F};
    logic [7:0]  bs  [4] = '{8'h20, 8'h01, 8'h55, 8'h01};
    // {Valid, Result, C, V, Z, N}
    logic [12:0] exp [4] = '{{1'b1, 8'h10, 4'b1000}, {1'b1, 8'h7F, 4'b0100},
                             {1'b1, 8'hFF, 4'b1001}, {1'b1, 8'h80, 4'b0101}};
    logic [12:0] got;
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], as[i], bs[i], 3'b001);
      got = {Result_Valid, Result, Flag_C, Flag_V, Flag_Z, Flag_N};
      tests++;
      if (got !== exp[i]) begin
        fails++; $display("FAIL arith_op%0h: got %h required %h", ops[i], got, exp[i]);
      end
      if (i == 0) begin
        tests++;
        if ({Busy, Op_Count} !== {1'b1, exp_cnt}) begin
          fails++; $display("FAIL done_busy_cnt: got %h required %h", {Busy, Op_Count},
                            {1'b1, exp_cnt});
        end
      end
      handshake();
      tests++;
      if ({Result_Valid, Busy, Op_Count} !== {2'b00, exp_cnt}) begin
        fails++; $display("FAIL arith_handshake%0d: got %h required %h", i,
                          {Result_Valid, Busy, Op_Count}, {2'b00, exp_cnt});
      end
    end
  endtask

  task automatic test_logic_cmp();
    logic [3:0]  ops [11] = '{4'h0, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB,
                              4'hE, 4'hC, 4'hD, 4'hC};
    logic [7:0]  as  [11] = '{8'hA5, 8'hA5, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F,
                              8'h05, 8'h05, 8'h03, 8'h80};
    logic [7:0]  bs  [11] = '{8'h11, 8'h11, 8'h0F, 8'h0F, 8'h0F, 8'h3C, 8'h3C,
                              8'h05, 8'h05, 8'h05, 8'h7F};
    // {Result, Z, N}; C and V must stay 0
    logic [9:0]  exp [11] = '{{8'hA5, 2'b01}, {8'h5A, 2'b00}, {8'h00, 2'b10},
                              {8'hFF, 2'b01}, {8'h00, 2'b10}, {8'h33, 2'b00},
                              {8'hCC, 2'b01}, {8'h01, 2'b00}, {8'h00, 2'b10},
                              {8'h01, 2'b00}, {8'h01, 2'b00}};
    logic [12:0] got;
    for (int i = 0; i < 11; i++) begin
      drive_op(ops[i], as[i], bs[i], 3'b010);
      got = {Result_Valid, Result, Flag_C, Flag_V, Flag_Z, Flag_N};
      tests++;
      if (got !== {1'b1, exp[i][9:2], 2'b00, exp[i][1:0]}) begin
        fails++; $display("FAIL logic_op%0h_%0d: got %h required %h", ops[i], i, got,
                          {1'b1, exp[i][9:2], 2'b00, exp[i][1:0]});
      end
      handshake();
    end
  endtask

  task automatic test_hold_back_to_back();
    logic [13:0] got;
    drive_op(4'h2, 8'h01, 8'h02, 3'b001);
    // New XOR request arrives while the add result is held.
    Controller_Output = 4'hA; dataA = 8'h0F; dataB = 8'hFF; Select = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      got = {Result_Valid, Busy, Result, Op_Count};
      tests++;
      if (got !== {2'b11, 8'h03, exp_cnt}) begin
        fails++; $display("FAIL hold_cycle%0d: got %h required %h", i, got,
                          {2'b11, 8'h03, exp_cnt});
      end
    end
    Result_Ready = 1'b1;
    @(negedge Clk);
    exp_cnt = exp_cnt + 1'b1;
    Controller_Output = 4'hF;
    tests++;
    if ({Result_Valid, Busy, Op_Count} !== {2'b01, exp_cnt}) begin
      fails++; $display("FAIL b2b_exec: got %h required %h", {Result_Valid, Busy, Op_Count},
                        {2'b01, exp_cnt});
    end
    @(negedge Clk);
    tests++;
    if ({Result_Valid, Result, Flag_C, Flag_V, Flag_Z, Flag_N} !== {1'b1, 8'hF0, 4'b0001}) begin
      fails++; $display("FAIL b2b_xor: got %h required %h",
                        {Result_Valid, Result, Flag_C, Flag_V, Flag_Z, Flag_N},
                        {1'b1, 8'hF0, 4'b0001});
    end
    @(negedge Clk);
    Result_Ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    tests++;
    if ({Result_Valid, Busy, Op_Count} !== {2'b00, exp_cnt}) begin
      fails++; $display("FAIL b2b_idle: got %h required %h", {Result_Valid, Busy, Op_Count},
                        {2'b00, exp_cnt});
    end
  endtask

  task automatic test_sel_err();
    drive_op(4'h7, 8'hF0, 8'h3C, 3'b001);
    tests++;
    if ({Result, Sel_Err} !== {8'hCF, SelCheck}) begin
      fails++; $display("FAIL sel_err_nand: got %h required %h", {Result, Sel_Err},
                        {8'hCF, SelCheck});
    end
    handshake();
    drive_op(4'h2, 8'h01, 8'h01, 3'b001);
    tests++;
    if ({Result, Sel_Err} !== {8'h02, 1'b0}) begin
      fails++; $display("FAIL sel_ok_add: got %h required %h", {Result, Sel_Err}, {8'h02, 1'b0});
    end
    handshake();
  endtask

  task automatic test_count_wrap();
    int n;
    n = (1 << CntW) - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      drive_op(4'h0, 8'(i), 8'h00, 3'b000);
      handshake();
    end
    tests++;
    if (Op_Count !== '0) begin
      fails++; $display("FAIL count_wrap: got %h required 0", Op_Count);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_cmp();
    test_hold_back_to_back();
    test_sel_err();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
